// File: rtl/icache_fill_responder_pkg.sv
// Shared cache/core types for the I-cache refill path: physical address, line type,
// refill FSM states and a line-alignment helper.
package icache_fill_responder_pkg;

  localparam int PADDR_W          = 34;
  localparam int ICACHE_LINE_SIZE = 32;

  typedef logic [PADDR_W-1:0]            paddr_t;
  typedef logic [ICACHE_LINE_SIZE*8-1:0] icache_line_t;

  // Kept here rather than inside the responder so trace/debug tooling can decode it.
  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RECV,
    DONE,
    DRAIN
  } fill_state_e;

  function automatic paddr_t line_base(input paddr_t addr, input int unsigned line_size);
    return addr & ~paddr_t'(line_size - 1);
  endfunction

endpackage

// File: rtl/icache_fill_responder.sv
// Turns an I-cache line refill request into a single memory-bus burst and assembles
// the returned beats into a full line; aborts drain the burst without delivering it.
module icache_fill_responder
  import icache_fill_responder_pkg::*;
#(
  parameter int LINE_SIZE = ICACHE_LINE_SIZE,
  parameter int BUS_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  paddr_t                 memAddr,
  input  logic                   memReadEnable,
  output logic                   memReadDone,
  output logic [LINE_SIZE*8-1:0] memReadValue,
  input  logic                   abort,
  output paddr_t                 busAddr,
  output logic                   busReadReq,
  input  logic                   busGrant,
  input  logic                   busReadValid,
  input  logic [BUS_WIDTH-1:0]   busReadData
);

  localparam int BEATS = LINE_SIZE * 8 / BUS_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  fill_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic             last_beat;

  assign last_beat = (cnt == LAST_BEAT);

  // NOTE: done is decoded from state instead of registered so an abort arriving in
  // the DONE cycle itself can still suppress the pulse.
  assign memReadDone = (state == DONE) && !abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the line buffer is reset along with the control state because it drives
      // memReadValue directly and must read as zero after reset.
      state        <= IDLE;
      cnt          <= '0;
      busReadReq   <= 1'b0;
      busAddr      <= '0;
      memReadValue <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (memReadEnable && !abort) begin
            busAddr    <= line_base(memAddr, LINE_SIZE);
            busReadReq <= 1'b1;
            state      <= REQ;
          end
        end

        REQ: begin
          // A grant seen together with abort still commits the memory side to a full burst.
          if (abort) begin
            busReadReq <= 1'b0;
            cnt        <= '0;
            state      <= busGrant ? DRAIN : IDLE;
          end else if (busGrant) begin
            busReadReq <= 1'b0;
            cnt        <= '0;
            state      <= RECV;
          end
        end

        RECV: begin
          if (abort) begin
            if (busReadValid) begin
              cnt   <= cnt + CNT_W'(1);
              state <= last_beat ? IDLE : DRAIN;
            end else begin
              state <= DRAIN;
            end
          end else if (busReadValid) begin
            for (int b = 0; b < BEATS; b++) begin
              if (cnt == CNT_W'(b)) memReadValue[b*BUS_WIDTH +: BUS_WIDTH] <= busReadData;
            end
            cnt <= cnt + CNT_W'(1);
            if (last_beat) state <= DONE;
          end
        end

        DONE: state <= IDLE;

        DRAIN: begin
          if (busReadValid) begin
            cnt <= cnt + CNT_W'(1);
            if (last_beat) state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_fill_responder.sv
// Directed-plus-random bench for icache_fill_responder (32-byte line, 32-bit bus, 8 beats);
// expected lines, addresses and pulse counts come from a simple line/beat model.
module tb_icache_fill_responder;

  localparam int LINE_SIZE = 32;
  localparam int BUS_WIDTH = 32;
  localparam int BEATS     = LINE_SIZE * 8 / BUS_WIDTH;
  localparam int LINE_W    = LINE_SIZE * 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [33:0]       memAddr;
  logic              memReadEnable;
  logic              memReadDone;
  logic [LINE_W-1:0] memReadValue;
  logic              abort;
  logic [33:0]       busAddr;
  logic              busReadReq;
  logic              busGrant;
  logic              busReadValid;
  logic [31:0]       busReadData;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int req_cnt  = 0;

  logic [LINE_W-1:0] last_line;

  always #5 clk = ~clk;

  icache_fill_responder #(
    .LINE_SIZE(LINE_SIZE),
    .BUS_WIDTH(BUS_WIDTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .memAddr      (memAddr),
    .memReadEnable(memReadEnable),
    .memReadDone  (memReadDone),
    .memReadValue (memReadValue),
    .abort        (abort),
    .busAddr      (busAddr),
    .busReadReq   (busReadReq),
    .busGrant     (busGrant),
    .busReadValid (busReadValid),
    .busReadData  (busReadData)
  );

  // Pulse/cycle counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (memReadDone === 1'b1) done_cnt++;
    if (busReadReq === 1'b1) req_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] line_addr(input logic [33:0] a);
    return (a / 34'd32) * 34'd32;
  endfunction

  function automatic logic [33:0] rand_addr();
    logic [33:0] r;
    r[31:0]  = $urandom;
    r[33:32] = 2'($urandom);
    return r;
  endfunction

  task automatic beat(input logic [31:0] data);
    busReadValid = 1'b1;
    busReadData  = data;
    tick();
    busReadValid = 1'b0;
  endtask

  // One complete refill: grant on the req_cycles-th REQ cycle, optional idle cycle
  // before beat gap_at, optional abort during the DONE cycle.
  task automatic refill(input logic [33:0] addr, input int req_cycles, input int gap_at,
                        input bit fixed, input bit abort_done, input string tag);
    logic [31:0]       words [BEATS];
    logic [LINE_W-1:0] exp_line;
    int                d0, r0;
    for (int i = 0; i < BEATS; i++) begin
      words[i] = fixed ? 32'(32'h1111_1111 * (i + 1)) : $urandom;
      exp_line[i*32 +: 32] = words[i];
    end
    d0 = done_cnt;
    r0 = req_cnt;
    memAddr       = addr;
    memReadEnable = 1'b1;
    tick();
    check({tag, " req_up"}, busReadReq, 1);
    check({tag, " bus_addr"}, busAddr, line_addr(addr));
    for (int c = 1; c <= req_cycles; c++) begin
      busGrant = (c == req_cycles);
      tick();
    end
    busGrant = 1'b0;
    check({tag, " req_len"}, req_cnt - r0, req_cycles);
    check({tag, " req_down"}, busReadReq, 0);
    for (int i = 0; i < BEATS; i++) begin
      if (i == gap_at) begin
        busReadValid = 1'b0;
        busReadData  = $urandom;
        tick();
      end
      busReadValid = 1'b1;
      busReadData  = words[i];
      if (i == BEATS - 1) begin
        #1;
        check({tag, " early_done"}, memReadDone, 0);
      end
      tick();
    end
    busReadValid = 1'b0;
    busReadData  = $urandom;
    if (abort_done) begin
      abort = 1'b1;
      #1;
      check({tag, " done_suppressed"}, memReadDone, 0);
    end else begin
      #1;
      check({tag, " done"}, memReadDone, 1);
    end
    check({tag, " line"}, memReadValue, exp_line);
    tick();
    abort         = 1'b0;
    memReadEnable = 1'b0;
    check({tag, " pulses"}, done_cnt - d0, abort_done ? 0 : 1);
    check({tag, " done_low"}, memReadDone, 0);
    check({tag, " idle_req"}, busReadReq, 0);
    check({tag, " line_hold"}, memReadValue, exp_line);
    last_line = exp_line;
  endtask

  initial begin
    logic [33:0] a, next_a;
    int          d0;

    rst = 1'b1; memAddr = '0; memReadEnable = 1'b0; abort = 1'b0;
    busGrant = 1'b0; busReadValid = 1'b0; busReadData = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst req", busReadReq, 0);
    check("rst addr", busAddr, 0);
    check("rst done", memReadDone, 0);
    check("rst line", memReadValue, 0);

    // Reference refill with fixed pattern and immediate grant.
    refill(34'h0_0000_1234, 1, -1, 1'b1, 1'b0, "basic");

    // Slow grant and a one-cycle hole between beats 3 and 4.
    refill(rand_addr(), 5, 4, 1'b0, 1'b0, "slow");

    // Stray data beats while idle must not touch the line.
    for (int i = 0; i < 3; i++) beat($urandom);
    check("stray line", memReadValue, last_line);
    check("stray req", busReadReq, 0);

    // Abort after three beats: five more beats are drained, the next request waits.
    d0 = done_cnt;
    a  = rand_addr();
    memAddr = a; memReadEnable = 1'b1;
    tick();
    busGrant = 1'b1;
    tick();
    busGrant = 1'b0;
    for (int i = 0; i < 3; i++) beat($urandom);
    abort = 1'b1; memReadEnable = 1'b0;
    tick();
    abort  = 1'b0;
    next_a = rand_addr();
    memAddr = next_a; memReadEnable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      beat($urandom);
      check("drain req", busReadReq, 0);
    end
    check("drain pulses", done_cnt - d0, 0);
    refill(next_a, 2, -1, 1'b0, 1'b0, "after_drain");

    // Abort in REQ before grant, then abort while idle.
    d0 = done_cnt;
    memAddr = rand_addr(); memReadEnable = 1'b1;
    tick();
    check("reqabort up", busReadReq, 1);
    abort = 1'b1; memReadEnable = 1'b0;
    tick();
    abort = 1'b0;
    check("reqabort down", busReadReq, 0);
    memReadEnable = 1'b1; abort = 1'b1;
    tick();
    check("idleabort req", busReadReq, 0);
    memReadEnable = 1'b0; abort = 1'b0;
    tick();
    check("reqabort pulses", done_cnt - d0, 0);

    // Abort coincident with the last beat goes straight back to idle.
    d0 = done_cnt;
    memAddr = rand_addr(); memReadEnable = 1'b1;
    tick();
    busGrant = 1'b1;
    tick();
    busGrant = 1'b0;
    for (int i = 0; i < BEATS - 1; i++) beat($urandom);
    abort = 1'b1; memReadEnable = 1'b0;
    beat($urandom);
    abort = 1'b0;
    check("lastabort done", memReadDone, 0);
    tick();
    check("lastabort pulses", done_cnt - d0, 0);
    refill(rand_addr(), 1, -1, 1'b0, 1'b0, "after_lastabort");

    // Abort in the DONE cycle suppresses the pulse.
    refill(rand_addr(), 3, 2, 1'b0, 1'b1, "doneabort");

    // Grant and abort together: a full burst of BEATS beats is drained.
    d0 = done_cnt;
    memAddr = rand_addr(); memReadEnable = 1'b1;
    tick();
    busGrant = 1'b1; abort = 1'b1; memReadEnable = 1'b0;
    tick();
    busGrant = 1'b0; abort = 1'b0;
    next_a = rand_addr();
    memAddr = next_a; memReadEnable = 1'b1;
    for (int i = 0; i < BEATS; i++) begin
      beat($urandom);
      check("grantabort req", busReadReq, 0);
    end
    check("grantabort pulses", done_cnt - d0, 0);
    refill(next_a, 1, -1, 1'b0, 1'b0, "after_grantabort");

    // Reset during beat 4 abandons the burst.
    memAddr = rand_addr(); memReadEnable = 1'b1;
    tick();
    busGrant = 1'b1;
    tick();
    busGrant = 1'b0;
    for (int i = 0; i < 4; i++) beat($urandom);
    rst = 1'b1; memReadEnable = 1'b0; busReadValid = 1'b1; busReadData = $urandom;
    tick();
    rst = 1'b0; busReadValid = 1'b0;
    check("midrst req", busReadReq, 0);
    check("midrst addr", busAddr, 0);
    check("midrst done", memReadDone, 0);
    check("midrst line", memReadValue, 0);
    refill(34'h0_0000_2000, 1, -1, 1'b0, 1'b0, "post_rst");

    // Randomized refills.
    for (int k = 0; k < 6; k++) begin
      int rq, gp;
      rq = 1 + int'($urandom_range(3, 0));
      gp = int'($urandom_range(BEATS, 0)) - 1;
      refill(rand_addr(), rq, gp, 1'b0, 1'b0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
